// File: rtl/pulse_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : pulse_peak_detector (with package package_settings)
// Description : Threshold pulse detector that reports the peak amplitude,
//               the time of the first peak and the pulse width, with holdoff.
// Revision    : 1.0 - initial release
// ============================================================================

package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

module pulse_peak_detector #(
  parameter int MIN_WIDTH = 3,
  parameter int HOLDOFF   = 8
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic signed [package_settings::SIZE_FILTER_DATA-1:0] filter_data,
  input  logic signed [package_settings::SIZE_FILTER_DATA-1:0] threshold,
  input  logic                                               peak_ready,
  output logic                                               peak_valid,
  output logic signed [package_settings::SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic        [31:0]                                 peak_time,
  output logic        [15:0]                                 peak_width,
  output logic        [15:0]                                 drop_count,
  output logic                                               busy
);

  localparam int          c_SFD        = package_settings::SIZE_FILTER_DATA;
  localparam logic [15:0] c_MIN_WIDTH  = 16'(MIN_WIDTH);
  localparam logic [15:0] c_HOLD_LAST  = 16'(HOLDOFF - 1);
  localparam logic [15:0] c_SAT16      = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic        [31:0]      r_ts;
  logic signed [c_SFD-1:0] r_max;
  logic        [31:0]      r_max_time;
  logic        [15:0]      r_width;
  logic        [15:0]      r_hold_cnt;
  logic                    w_over;
  logic                    w_emit;
  logic                    w_load;

  assign w_over = filter_data > threshold;
  assign busy   = (r_state != ST_IDLE);
  // A new record may replace the current one only if it is absent or being consumed now.
  assign w_load = w_emit && (!peak_valid || peak_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_over) begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!w_over) begin
          if (r_width >= c_MIN_WIDTH) begin
            w_emit       = 1'b1;
            w_state_next = ST_HOLDOFF;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt == c_HOLD_LAST) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts           <= '0;
      r_max          <= '0;
      r_max_time     <= '0;
      r_width        <= '0;
      r_hold_cnt     <= '0;
      peak_valid     <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      peak_width     <= '0;
      drop_count     <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;

      case (r_state)
        ST_IDLE: begin
          r_hold_cnt <= '0;
          if (w_over) begin
            r_max      <= filter_data;
            r_max_time <= r_ts;
            r_width    <= 16'd1;
          end
        end
        ST_ARMED: begin
          r_hold_cnt <= '0;
          if (w_over) begin
            if (r_width != c_SAT16) begin
              r_width <= r_width + 16'd1;
            end
            // Strict compare keeps the earliest sample of a tied maximum.
            if (filter_data > r_max) begin
              r_max      <= filter_data;
              r_max_time <= r_ts;
            end
          end
        end
        ST_HOLDOFF: begin
          if (r_hold_cnt == c_HOLD_LAST) begin
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
          end
        end
        default: begin
          r_hold_cnt <= '0;
        end
      endcase

      if (w_load) begin
        peak_valid     <= 1'b1;
        peak_amplitude <= r_max;
        peak_time      <= r_max_time;
        peak_width     <= r_width;
      end else if (peak_ready) begin
        peak_valid <= 1'b0;
      end

      if (w_emit && !w_load && (drop_count != c_SAT16)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_peak_detector
// Description : Directed bench for pulse_peak_detector with a queue-based
//               pulse model checked every cycle on two parameterisations.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_pulse_peak_detector;

  localparam int SFD  = package_settings::SIZE_FILTER_DATA;
  localparam int HOLD = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic signed [SFD-1:0] filter_data = '0;
  logic signed [SFD-1:0] threshold = SFD'(100);
  logic                  peak_ready = 1'b1;

  logic                  pv [2];
  logic signed [SFD-1:0] pa [2];
  logic        [31:0]    pt [2];
  logic        [15:0]    pw [2];
  logic        [15:0]    dc [2];
  logic                  bz [2];

  always #5 clk = ~clk;

  pulse_peak_detector #(.MIN_WIDTH(3), .HOLDOFF(HOLD)) dut0 (
    .clk(clk), .reset(reset), .filter_data(filter_data), .threshold(threshold),
    .peak_ready(peak_ready), .peak_valid(pv[0]), .peak_amplitude(pa[0]),
    .peak_time(pt[0]), .peak_width(pw[0]), .drop_count(dc[0]), .busy(bz[0])
  );

  pulse_peak_detector #(.MIN_WIDTH(2), .HOLDOFF(HOLD)) dut1 (
    .clk(clk), .reset(reset), .filter_data(filter_data), .threshold(threshold),
    .peak_ready(peak_ready), .peak_valid(pv[1]), .peak_amplitude(pa[1]),
    .peak_time(pt[1]), .peak_width(pw[1]), .drop_count(dc[1]), .busy(bz[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: the pulse is the queue of over-threshold samples; its record is derived at the fall.
  int                    minw [2] = '{3, 2};
  bit                    m_init = 1'b0;
  logic        [31:0]    m_ts = '0;
  logic signed [SFD-1:0] qa [2][$];
  logic        [31:0]    qt [2][$];
  int                    hold_left [2];
  bit                    e_valid [2];
  logic signed [SFD-1:0] e_amp [2];
  logic        [31:0]    e_time [2];
  logic        [15:0]    e_wid [2];
  logic        [15:0]    e_drop [2];
  int                    wrap_seq = 0;
  int                    seen_seq = 0;
  logic        [31:0]    wrap_val = '0;

  function automatic void mstep(input int k, input logic signed [SFD-1:0] s);
    bit                    over;
    bit                    was_valid;
    logic signed [SFD-1:0] best;
    logic        [31:0]    best_t;
    over      = s > threshold;
    was_valid = e_valid[k];
    if (was_valid && peak_ready) e_valid[k] = 1'b0;
    if (hold_left[k] > 0) begin
      hold_left[k]--;
    end else if (over) begin
      qa[k].push_back(s);
      qt[k].push_back(m_ts);
    end else if (qa[k].size() > 0) begin
      if (qa[k].size() >= minw[k]) begin
        best   = qa[k][0];
        best_t = qt[k][0];
        for (int i = 1; i < qa[k].size(); i++) begin
          if (qa[k][i] > best) begin
            best   = qa[k][i];
            best_t = qt[k][i];
          end
        end
        if (!was_valid || peak_ready) begin
          e_valid[k] = 1'b1;
          e_amp[k]   = best;
          e_time[k]  = best_t;
          e_wid[k]   = (qa[k].size() > 65535) ? 16'hFFFF : 16'(qa[k].size());
        end else if (e_drop[k] != 16'hFFFF) begin
          e_drop[k]++;
        end
        hold_left[k] = HOLD;
      end
      qa[k].delete();
      qt[k].delete();
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1'b1;
      m_ts   = '0;
      for (int k = 0; k < 2; k++) begin
        qa[k].delete();
        qt[k].delete();
        hold_left[k] = 0;
        e_valid[k]   = 1'b0;
        e_amp[k]     = '0;
        e_time[k]    = '0;
        e_wid[k]     = '0;
        e_drop[k]    = '0;
      end
    end else begin
      if (wrap_seq != seen_seq) begin
        m_ts     = wrap_val;
        seen_seq = wrap_seq;
      end
      for (int k = 0; k < 2; k++) mstep(k, filter_data);
      m_ts = m_ts + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d.valid", k), 64'(pv[k]), 64'(e_valid[k]));
        chk($sformatf("dut%0d.amplitude", k), 64'(pa[k]), 64'(e_amp[k]));
        chk($sformatf("dut%0d.time", k), 64'(pt[k]), 64'(e_time[k]));
        chk($sformatf("dut%0d.width", k), 64'(pw[k]), 64'(e_wid[k]));
        chk($sformatf("dut%0d.drops", k), 64'(dc[k]), 64'(e_drop[k]));
        chk($sformatf("dut%0d.busy", k), 64'(bz[k]),
            64'((qa[k].size() > 0) || (hold_left[k] > 0)));
      end
    end
  end

  task automatic step(input int s);
    filter_data = SFD'(s);
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic idle(input int n, input int s);
    for (int i = 0; i < n; i++) step(s);
  endtask

  initial begin
    logic [31:0] t_first;
    repeat (3) @(posedge clk);
    #2;
    chk("reset.valid", 64'(pv[0]), 64'd0);
    chk("reset.amplitude", 64'(pa[0]), 64'd0);
    chk("reset.time", 64'(pt[0]), 64'd0);
    chk("reset.drops", 64'(dc[0]), 64'd0);
    chk("reset.busy", 64'(bz[0]), 64'd0);
    reset = 1'b0;
    cyc   = 0;

    // Basic pulse at ts 0..5
    step(0); step(0); step(150);
    chk("basic.busy_ts3", 64'(bz[0]), 64'd1);
    step(300); step(200); step(50);
    chk("basic.valid_ts6", 64'(pv[0]), 64'd1);
    chk("basic.amplitude", 64'(pa[0]), 64'(SFD'(300)));
    chk("basic.time", 64'(pt[0]), 64'd3);
    chk("basic.width", 64'(pw[0]), 64'd3);
    step(0);
    chk("basic.valid_drop", 64'(pv[0]), 64'd0);
    idle(10, 0);

    // Runt, then tie
    step(150); step(120); step(40);
    chk("runt.no_valid", 64'(pv[0]), 64'd0);
    chk("runt.minw2_width", 64'(pw[1]), 64'd2);
    idle(10, 0);
    step(150);
    t_first = 32'(cyc);
    step(300); step(300); step(50);
    chk("tie.amplitude", 64'(pa[0]), 64'(SFD'(300)));
    chk("tie.time", 64'(pt[0]), 64'(t_first));
    idle(10, 0);

    // Holdoff: eight over-threshold samples ignored, then re-arm in first IDLE cycle
    step(150); step(150); step(150); step(50);
    idle(HOLD, 200);
    step(220); step(230); step(240); step(50);
    chk("holdoff.valid", 64'(pv[0]), 64'd1);
    chk("holdoff.amplitude", 64'(pa[0]), 64'(SFD'(240)));
    chk("holdoff.width", 64'(pw[0]), 64'd3);
    idle(10, 0);

    // Backpressure
    peak_ready = 1'b0;
    step(150); step(250); step(150); step(0);
    idle(10, 0);
    step(180); step(190); step(200); step(0);
    chk("bp.valid_held", 64'(pv[0]), 64'd1);
    chk("bp.amplitude_held", 64'(pa[0]), 64'(SFD'(250)));
    chk("bp.drops", 64'(dc[0]), 64'd1);
    idle(9, 0);
    peak_ready = 1'b1;
    step(0);
    chk("bp.valid_cleared", 64'(pv[0]), 64'd0);
    idle(2, 0);

    // Threshold raised while armed ends the pulse on the next sample
    step(150); step(150);
    threshold = SFD'(200);
    step(160);
    threshold = SFD'(100);
    idle(10, 0);

    // Reset mid-pulse
    step(150); step(300); step(200);
    reset = 1'b1;
    step(0); step(0);
    chk("rst.valid", 64'(pv[0]), 64'd0);
    chk("rst.busy", 64'(bz[0]), 64'd0);
    chk("rst.drops", 64'(dc[0]), 64'd0);
    reset = 1'b0;
    cyc   = 0;
    step(0); step(150); step(160); step(170); step(0);
    chk("rst.after_time", 64'(pt[0]), 64'd3);
    chk("rst.after_amp", 64'(pa[0]), 64'(SFD'(170)));
    idle(10, 0);

    // Negative threshold
    threshold = SFD'(-50);
    idle(2, -100);
    step(-10); step(-20); step(-60);
    chk("neg.valid", 64'(pv[1]), 64'd1);
    chk("neg.amplitude", 64'(pa[1]), 64'(SFD'(-10)));
    chk("neg.width", 64'(pw[1]), 64'd2);
    idle(10, -100);
    threshold = SFD'(100);
    step(0);

    // Timestamp wrap
    wrap_val = 32'hFFFF_FFFD;
    force dut0.r_ts = 32'hFFFF_FFFD;
    force dut1.r_ts = 32'hFFFF_FFFD;
    wrap_seq++;
    #1;
    release dut0.r_ts;
    release dut1.r_ts;
    step(150); step(300); step(200); step(250); step(0);
    chk("wrap.time", 64'(pt[0]), 64'h0000_0000_FFFF_FFFE);
    chk("wrap.width", 64'(pw[0]), 64'd4);
    idle(10, 0);
    step(150); step(400); step(150); step(0);
    chk("wrap.after_time", 64'(pt[0]), 64'd13);
    idle(10, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, limit 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/pulse_peak_detector.md
PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 3: minimum over-threshold samples for a valid pulse (range 1..65535).
REQ-002 SHALL have parameter HOLDOFF, default 8: dead-time cycles after each emitted pulse (range 1..65535).
REQ-003 SHALL take widths from package_settings::SIZE_FILTER_DATA (SFD).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port filter_data, input, SFD signed, shaped-filter sample, valid every clk.
REQ-007 SHALL have port threshold, input, SFD signed, trigger level, sampled live every clk.
REQ-008 SHALL have port peak_ready, input, 1, consumer accepts the current peak.
REQ-009 SHALL have port peak_valid, output, 1, the peak record is valid.
REQ-010 SHALL have port peak_amplitude, output, SFD signed, maximum sample of the pulse.
REQ-011 SHALL have port peak_time, output, 32, timestamp of the first maximum sample.
REQ-012 SHALL have port peak_width, output, 16, count of over-threshold samples.
REQ-013 SHALL have port drop_count, output, 16, peaks lost to backpressure.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL keep a 32-bit free-running counter ts that increments every clk and wraps from 0xFFFFFFFF to 0; each sample is stamped with the ts value at the edge where it is registered.
REQ-016 SHALL compare samples to threshold as signed values, strictly greater-than.
REQ-017 SHALL implement states IDLE, ARMED and HOLDOFF.
REQ-018 IDLE: a sample greater than threshold SHALL cause a move to ARMED with max set to the sample, max_time set to ts, and width set to 1; otherwise the block stays in IDLE.
REQ-019 ARMED, sample greater than threshold: width SHALL increment, saturating at 65535.
REQ-020 ARMED, sample greater than threshold: max and max_time SHALL update only when sample > max, so the first occurrence of a tie is kept.
REQ-021 ARMED, sample less than or equal to threshold with width >= MIN_WIDTH: the block SHALL emit the peak and go to HOLDOFF.
REQ-022 ARMED, sample less than or equal to threshold with width < MIN_WIDTH: the block SHALL discard the pulse silently and go to IDLE.
REQ-023 HOLDOFF: the block SHALL ignore input for exactly HOLDOFF cycles, then enter IDLE; a sample in the first IDLE cycle can re-arm.
REQ-024 Emission SHALL be registered: peak_valid and the record appear on the clk after the falling sample is registered, so latency is 1 cycle.
REQ-025 Handshake: the record SHALL be held stable while peak_valid=1 and peak_ready=0.
REQ-026 Handshake: peak_valid SHALL drop on the clk after peak_valid=1 and peak_ready=1, unless a new emission loads in that same cycle.
REQ-027 An emission SHALL load the output register if peak_valid=0, or if peak_valid=1 and peak_ready=1 in the same cycle.
REQ-028 Otherwise the emission SHALL be dropped: the record stays unchanged and drop_count increments, saturating at 0xFFFF.
REQ-029 Threshold changes while ARMED SHALL take effect on the next sample; there is no hysteresis.
REQ-030 A pulse that never falls SHALL remain in ARMED indefinitely, with width saturated and no emission.
REQ-031 A peak_time captured before ts wraps SHALL be reported unmodified.

Reset
REQ-032 While reset=1 at a clk edge, the block SHALL set state=IDLE, ts=0, max=0, max_time=0, width=0, holdoff counter=0, peak_valid=0, peak_amplitude=0, peak_time=0, peak_width=0, drop_count=0 and busy=0.
REQ-033 Reset mid-pulse or mid-holdoff SHALL abort without emission; ts restarts at 0 the cycle after reset releases.

Verification (threshold=100, MIN_WIDTH=3, HOLDOFF=8, peak_ready=1 unless stated)
REQ-034 Basic pulse: samples 0,0,150,300,200,50 at ts=0..5 -> peak_valid high one cycle at ts=6 with amplitude=300, time=3, width=3; busy from ts=3 to end of holdoff.
REQ-035 Runt and tie: samples 150,120,40 -> no peak_valid; then samples 150,300,300,50 -> amplitude=300, with time equal to the ts of the first 300 sample.
REQ-036 Backpressure: peak_ready=0 with two valid pulses separated by more than the holdoff -> first record held unchanged, second dropped, drop_count=1; raising peak_ready clears peak_valid next cycle.
REQ-037 Holdoff: a pulse starting within 8 cycles of the end of an emitted pulse -> ignored; a pulse starting in the first IDLE cycle -> detected.
REQ-038 Reset mid-pulse: reset=1 while ARMED with max=300 -> no emission, all outputs 0; a following pulse reports ts counted from the release of reset.
REQ-039 Negative and wrap: threshold=-50 with samples -10,-20,-60 and MIN_WIDTH=2 -> amplitude=-10; ts forced to wrap -> ts continues from 0 with no glitch.
